datamover_rd_checker: RTL

- Read-side counterpart of the datamover write validation: issues one MM2S read command, consumes the MM2S data and status streams, and checks every beat against the pattern the S2MM write path produced.
- Sits beside the validation block in the datamover test harness, driven from VIO.
- Reports pass/fail, a saturating error count and first-failure capture.

---
 rtl/datamover_pkg.sv | 57 +++++
 rtl/datamover_pattern_chk.sv | 49 ++++
 rtl/datamover_rd_checker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/datamover_pkg.sv
// Shared types, MM2S command layout and status decoding for the datamover read checker.
package datamover_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_RD_STS,
        ST_DONE
    } state_t;

    // MM2S command field offsets; address width is a parameter of the user.
    localparam int CMD_BTT_LSB  = 0;
    localparam int CMD_TYPE_LSB = 23;
    localparam int CMD_EOF_BIT  = 30;
    localparam int CMD_DRR_BIT  = 31;
    localparam int CMD_ADDR_LSB = 32;

    localparam int MAX_AW    = 64;
    localparam int CMD_MAX_W = 40 + MAX_AW;

    localparam logic [3:0] MM2S_TAG = 4'hB;

    localparam int STS_TAG_LSB = 0;
    localparam int STS_INTERR  = 4;
    localparam int STS_DECERR  = 5;
    localparam int STS_SLVERR  = 6;
    localparam int STS_OKAY    = 7;

    localparam int ERR_DATA     = 0;
    localparam int ERR_KEEP     = 1;
    localparam int ERR_EARLY    = 2;
    localparam int ERR_NO_LAST  = 3;
    localparam int ERR_STS      = 4;
    localparam int ERR_TIMEOUT  = 5;
    localparam int ERR_ZERO_LEN = 6;

    // Caller zero-extends addr and truncates the result to 40+aw bits.
    function automatic logic [CMD_MAX_W-1:0] mm2s_cmd(input logic [MAX_AW-1:0] addr,
                                                     input logic [15:0]       btt,
                                                     input logic [3:0]        tag,
                                                     input int                aw);
        logic [CMD_MAX_W-1:0] cmd;
        cmd = '0;
        cmd[CMD_BTT_LSB +: 16] = btt;
        cmd[CMD_TYPE_LSB +: 7] = 7'd1;
        cmd[CMD_EOF_BIT]       = 1'b1;
        cmd[CMD_DRR_BIT]       = 1'b0;
        cmd = cmd | (CMD_MAX_W'(addr) << CMD_ADDR_LSB) | (CMD_MAX_W'(tag) << (CMD_ADDR_LSB + aw));
        return cmd;
    endfunction

    function automatic logic [7:0] last_keep(input logic [15:0] len);
        return (len[2:0] == 3'd0) ? 8'hFF : ((8'd1 << len[2:0]) - 8'd1);
    endfunction

endpackage

// File: rtl/datamover_pattern_chk.sv
// Compares one accepted beat against the incrementing pattern; owns the saturating
// mismatch counter and first-failure capture.
module datamover_pattern_chk
    import datamover_pkg::*;
#(
    parameter logic [63:0] INIT_DATA = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        beat_vld,
    input  logic [15:0] beat_idx,
    input  logic [63:0] beat_data,
    input  logic [7:0]  beat_keep,
    input  logic [7:0]  exp_keep,
    output logic        data_err,
    output logic        keep_err,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_beat,
    output logic [63:0] first_err_data
);

    logic [63:0] exp_data;

    assign exp_data = INIT_DATA + 64'(beat_idx);
    assign data_err = beat_vld && (beat_data != exp_data);
    assign keep_err = beat_vld && (beat_keep != exp_keep);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt        <= '0;
            first_err_beat <= '0;
            first_err_data <= '0;
        end else if (clr) begin
            err_cnt        <= '0;
            first_err_beat <= '0;
            first_err_data <= '0;
        end else if (data_err || keep_err) begin
            // The counter never returns to zero once bumped, so zero marks "first".
            if (err_cnt == 16'd0) begin
                first_err_beat <= beat_idx;
                first_err_data <= beat_data;
            end
            if (err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/datamover_rd_checker.sv
// Issues one MM2S read command, checks the returned beats and status against the
// S2MM write pattern, and reports pass/fail with sticky error flags.
module datamover_rd_checker
    import datamover_pkg::*;
#(
    parameter int          DDR_ADDR_WIDTH = 40,
    parameter logic [63:0] INIT_DATA      = 64'd0,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [15:0]                  i_rd_length,
    input  logic [DDR_ADDR_WIDTH-1:0]    i_start_rd_addr,
    input  logic                         i_throttle,
    input  logic                         i_mm2s_rd_cmd_tready,
    output logic [40+DDR_ADDR_WIDTH-1:0] o_mm2s_rd_cmd_tdata,
    output logic                         o_mm2s_rd_cmd_tvalid,
    input  logic [63:0]                  i_mm2s_rd_tdata,
    input  logic [7:0]                   i_mm2s_rd_tkeep,
    input  logic                         i_mm2s_rd_tvalid,
    input  logic                         i_mm2s_rd_tlast,
    output logic                         o_mm2s_rd_tready,
    input  logic [7:0]                   i_mm2s_sts_tdata,
    input  logic                         i_mm2s_sts_tvalid,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_pass,
    output logic [6:0]                   o_err_flags,
    output logic [15:0]                  o_err_cnt,
    output logic [15:0]                  o_first_err_beat,
    output logic [63:0]                  o_first_err_data
);

    localparam int          CMD_W   = 40 + DDR_ADDR_WIDTH;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t      state, state_nxt;
    logic        start_r, start_p, start_ok;
    logic [15:0] beats_q, beat_k;
    logic [7:0]  last_keep_q, exp_keep;
    logic [CMD_W-1:0] cmd_q;
    logic        overrun;
    logic [31:0] tcnt;
    logic [6:0]  flags_nxt;
    logic        beat_acc, cmp_vld, last_beat, sts_acc, sts_bad;
    logic        timeout_hit, enter_done, data_err, keep_err;

    assign start_ok  = start_p && (state == ST_IDLE || state == ST_DONE);
    assign beat_acc  = o_mm2s_rd_tready && i_mm2s_rd_tvalid;
    assign cmp_vld   = beat_acc && !overrun;
    assign last_beat = (beat_k == beats_q - 16'd1);
    assign exp_keep  = last_beat ? last_keep_q : 8'hFF;
    assign sts_acc   = (state == ST_RD_STS) && i_mm2s_sts_tvalid;
    assign sts_bad   = !i_mm2s_sts_tdata[STS_OKAY] || i_mm2s_sts_tdata[STS_INTERR]
                    || i_mm2s_sts_tdata[STS_DECERR] || i_mm2s_sts_tdata[STS_SLVERR]
                    || (i_mm2s_sts_tdata[STS_TAG_LSB +: 4] != MM2S_TAG);
    assign timeout_hit = TO_EN && (state == ST_RD_DATA || state == ST_RD_STS)
                      && !beat_acc && (tcnt == TO_LAST);
    assign enter_done  = (state_nxt == ST_DONE) && (state != ST_DONE || start_ok);
    assign o_mm2s_rd_cmd_tdata = cmd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE:
                if (start_ok)
                    state_nxt = (i_rd_length == 16'd0) ? ST_DONE : ST_RD_CMD;
            ST_RD_CMD:
                if (i_mm2s_rd_cmd_tready)
                    state_nxt = ST_RD_DATA;
            ST_RD_DATA:
                if (beat_acc && i_mm2s_rd_tlast)
                    state_nxt = ST_RD_STS;
                else if (timeout_hit)
                    state_nxt = ST_DONE;
            ST_RD_STS:
                if (sts_acc || timeout_hit)
                    state_nxt = ST_DONE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy               = 1'b0;
        o_mm2s_rd_cmd_tvalid = 1'b0;
        o_mm2s_rd_tready     = 1'b0;
        case (state)
            ST_RD_CMD: begin
                o_busy               = 1'b1;
                o_mm2s_rd_cmd_tvalid = 1'b1;
            end
            ST_RD_DATA: begin
                o_busy           = 1'b1;
                o_mm2s_rd_tready = ~i_throttle;
            end
            ST_RD_STS: o_busy = 1'b1;
            default: ;
        endcase
    end

    // Once the expected last beat passes without tlast, later beats are drained unchecked.
    always_comb begin
        flags_nxt = o_err_flags;
        if (start_ok) begin
            flags_nxt = '0;
            flags_nxt[ERR_ZERO_LEN] = (i_rd_length == 16'd0);
        end else begin
            if (data_err) flags_nxt[ERR_DATA] = 1'b1;
            if (keep_err) flags_nxt[ERR_KEEP] = 1'b1;
            if (cmp_vld && i_mm2s_rd_tlast && !last_beat)  flags_nxt[ERR_EARLY]   = 1'b1;
            if (cmp_vld && !i_mm2s_rd_tlast && last_beat)  flags_nxt[ERR_NO_LAST] = 1'b1;
            if (sts_acc && sts_bad) flags_nxt[ERR_STS]     = 1'b1;
            if (timeout_hit)        flags_nxt[ERR_TIMEOUT] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r     <= 1'b0;
            start_p     <= 1'b0;
            beats_q     <= '0;
            last_keep_q <= '0;
            cmd_q       <= '0;
            beat_k      <= '0;
            overrun     <= 1'b0;
            tcnt        <= '0;
            o_err_flags <= '0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
        end else begin
            start_r     <= i_start;
            start_p     <= i_start & ~start_r;
            o_err_flags <= flags_nxt;
            o_done      <= enter_done;
            if (start_ok) begin
                beats_q     <= {3'b000, i_rd_length[15:3]} + 16'(|i_rd_length[2:0]);
                last_keep_q <= last_keep(i_rd_length);
                cmd_q       <= CMD_W'(mm2s_cmd(MAX_AW'(i_start_rd_addr), i_rd_length,
                                               MM2S_TAG, DDR_ADDR_WIDTH));
                beat_k      <= '0;
                overrun     <= 1'b0;
                o_pass      <= 1'b0;
            end else if (beat_acc) begin
                beat_k <= beat_k + 16'd1;
                if (cmp_vld && !i_mm2s_rd_tlast && last_beat)
                    overrun <= 1'b1;
            end
            if (enter_done)
                o_pass <= (flags_nxt == 7'd0);
            if (state_nxt != state || beat_acc)
                tcnt <= '0;
            else if (state == ST_RD_DATA || state == ST_RD_STS)
                tcnt <= tcnt + 32'd1;
        end
    end

    datamover_pattern_chk #(
        .INIT_DATA (INIT_DATA)
    ) u_pattern_chk (
        .clk            (clk),
        .rst            (rst),
        .clr            (start_ok),
        .beat_vld       (cmp_vld),
        .beat_idx       (beat_k),
        .beat_data      (i_mm2s_rd_tdata),
        .beat_keep      (i_mm2s_rd_tkeep),
        .exp_keep       (exp_keep),
        .data_err       (data_err),
        .keep_err       (keep_err),
        .err_cnt        (o_err_cnt),
        .first_err_beat (o_first_err_beat),
        .first_err_data (o_first_err_data)
    );

endmodule
